// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed scanner for a four-digit common-anode
// seven-segment display. A 16-bit hex value and four decimal-point requests
// are captured into a shadow register on load. They are copied into the
// display register only at the end of a full frame, so a value never tears
// across digits. Anode enables rotate AN0..AN3, and each slot starts with
// a blanking gap to suppress ghosting.
//
// Optional build macro: LEADING_ZERO_BLANK_EN. When it is defined, leading
// zero digits (3..1) are kept dark unless their decimal point is requested.
//
// Interface semantics: load is a single-cycle capture strobe with no ready.
// Every cycle in which load is high overwrites the shadow register. On the
// frame-boundary cycle, a load bypasses the shadow and goes straight into
// the display register. All outputs are registered and present a new value
// every clock.
module seg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_in,
  output logic [3:0]  nibble,
  output logic [3:0]  enable,
  output logic        dp,
  output logic [1:0]  digit_idx
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  // scan position
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;

  // captured and displayed data
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [15:0] display_q, display_d;
  logic [3:0]  display_dp_q, display_dp_d;

  // registered outputs
  logic [3:0] enable_q, enable_d;
  logic [3:0] nibble_q, nibble_d;
  logic       dp_q, dp_d;
  logic [1:0] digit_idx_q, digit_idx_d;

  logic cnt_last;
  logic frame_end;
  logic in_blank;
  logic suppress;

  // Blanking window at the start of each slot; no window at all when zero.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt_q < BLANK_LIM);
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // Dark leading-zero digits, judged from the frame-stable display register.
  always_comb begin
    suppress = 1'b0;
    case (dig_q)
      2'd1:    suppress = (display_q[15:4]  == 12'h000) && !display_dp_q[1];
      2'd2:    suppress = (display_q[15:8]  == 8'h00)   && !display_dp_q[2];
      2'd3:    suppress = (display_q[15:12] == 4'h0)    && !display_dp_q[3];
      default: suppress = 1'b0;
    endcase
  end
`else
  assign suppress = 1'b0;
`endif

  // Prescaler and digit rotation; frame ends on the last cycle of digit 3.
  always_comb begin
    cnt_last  = (cnt_q == CNT_LAST);
    frame_end = cnt_last && (dig_q == 2'd3);
    cnt_d     = cnt_last ? '0 : cnt_q + CNT_W'(1);
    dig_d     = cnt_last ? dig_q + 2'd1 : dig_q;
  end

  // Shadow capture on load; display refresh only at the frame boundary,
  // with the same-cycle load taking precedence over the shadow.
  always_comb begin
    shadow_d     = shadow_q;
    shadow_dp_d  = shadow_dp_q;
    display_d    = display_q;
    display_dp_d = display_dp_q;
    if (load) begin
      shadow_d    = value;
      shadow_dp_d = dp_in;
    end
    if (frame_end) begin
      display_d    = load ? value : shadow_q;
      display_dp_d = load ? dp_in : shadow_dp_q;
    end
  end

  // Next output values from the current scan position and display contents.
  always_comb begin
    digit_idx_d = dig_q;
    case (dig_q)
      2'd0:    nibble_d = display_q[3:0];
      2'd1:    nibble_d = display_q[7:4];
      2'd2:    nibble_d = display_q[11:8];
      default: nibble_d = display_q[15:12];
    endcase
    if (in_blank || suppress) begin
      enable_d = 4'b1111;
    end else begin
      enable_d = ~(4'b0001 << dig_q);
    end
    // The decimal point is held off while all anodes are off.
    dp_d = in_blank ? 1'b1 : ~display_dp_q[dig_q];
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      dig_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      display_q    <= 16'h0000;
      display_dp_q <= 4'h0;
      enable_q     <= 4'b1111;
      nibble_q     <= 4'h0;
      dp_q         <= 1'b1;
      digit_idx_q  <= 2'd0;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      display_q    <= display_d;
      display_dp_q <= display_dp_d;
      enable_q     <= enable_d;
      nibble_q     <= nibble_d;
      dp_q         <= dp_d;
      digit_idx_q  <= digit_idx_d;
    end
  end

  assign enable    = enable_q;
  assign nibble    = nibble_q;
  assign dp        = dp_q;
  assign digit_idx = digit_idx_q;

endmodule
